// File: rtl/dm_arbiter_pkg.sv
// Shared sizing for the data memory port and its arbiter. The dm and the CPU
// top both import these defaults so that address and data widths agree.
package dm_arbiter_pkg;
  localparam int DM_ADDR_W   = 7;
  localparam int DM_DATA_W   = 32;
  localparam int DM_MAX_WAIT = 4;
  localparam int DM_CNT_W    = 16;
  localparam int WAIT_W      = 8;
endpackage

// File: rtl/dm_arb_wait.sv
// Counts how long a DMA request has waited behind CPU traffic and raises
// force_gnt once it has waited MAX_WAIT cycles.
module dm_arb_wait
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DM_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_gnt
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // A grant or a dropped request restarts the wait; a pending request saturates.
  always_ff @(posedge clk) begin
    if (reset || dma_gnt || !dma_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign force_gnt = (wait_cnt == WAIT_LIMIT);

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the MEM stage and a DMA/debug
// requester. The CPU owns the port unless DMA finds it idle or has waited too long.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int MAX_WAIT = DM_MAX_WAIT,
  parameter int CNT_W    = DM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [CNT_W-1:0]  stall_count
);

  // Handshake: dma_req is held with dma_we/dma_addr/dma_wdata stable until
  // dma_gnt; the access happens in exactly the cycle dma_gnt is high. A read
  // returns dma_rdata with a one-cycle dma_rvalid pulse; there is no back-pressure.

  logic cpu_act;
  logic force_gnt;
  logic dma_own;

  dm_arb_wait #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk       (clk),
    .reset     (reset),
    .dma_req   (dma_req),
    .dma_gnt   (dma_gnt),
    .force_gnt (force_gnt)
  );

  assign cpu_act = cpu_rd | cpu_wr;
  assign dma_own = dma_req & (~cpu_act | force_gnt);

  always_comb begin
    dm_addr   = cpu_addr;
    dm_rd     = cpu_rd;
    dm_wr     = cpu_wr;
    dm_wdata  = cpu_wdata;
    dma_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (dma_own) begin
      dm_addr   = dma_addr;
      dm_rd     = ~dma_we;
      dm_wr     = dma_we;
      dm_wdata  = dma_wdata;
      dma_gnt   = 1'b1;
      cpu_stall = cpu_act;
    end
  end

  assign cpu_rdata = dm_rdata;

  // Read data is captured on the grant edge and held until the next read grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_own & ~dma_we;
      if (dma_own && !dma_we) begin
        dma_rdata <= dm_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (cpu_stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a driver issues per-cycle vectors and pushes
// hand-computed grant/return/register expectations; a negedge monitor checks them.
module tb_dm_arbiter;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_rd = 1'b0;
  logic              cpu_wr = 1'b0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req = 1'b0;
  logic              dma_we = 1'b0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_rd;
  logic              dm_wr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic [CNT_W-1:0]  stall_count;

  dm_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_gnt     (dma_gnt),
    .dma_rdata   (dma_rdata),
    .dma_rvalid  (dma_rvalid),
    .dm_addr     (dm_addr),
    .dm_rd       (dm_rd),
    .dm_wr       (dm_wr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .stall_count (stall_count)
  );

  // ---------------- clock / cycle counter / memory model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;
  assign dm_rdata = mem[dm_addr];

  // ---------------- scoreboard queues ----------------
  // gnt entry: {cyc, cpu_stall, dm_wr, dm_rd, dm_addr, dm_wdata}
  logic [57:0] gnt_q[$];
  // read-return entry: {cyc, dma_rdata}
  logic [47:0] rd_q[$];
  // register snapshot: {cyc, dma_rvalid, dma_rdata, stall_count}
  logic [52:0] reg_q[$];

  int   checks = 0;
  int   failures = 0;
  logic done = 1'b0;
  logic leftovers_done = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic crd, input logic cwr,
                       input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cwdata,
                       input logic req, input logic we,
                       input logic [ADDR_W-1:0] daddr, input logic [DATA_W-1:0] dwdata);
    @(posedge clk);
    #1;
    reset     = rst;
    cpu_rd    = crd;
    cpu_wr    = cwr;
    cpu_addr  = caddr;
    cpu_wdata = cwdata;
    dma_req   = req;
    dma_we    = we;
    dma_addr  = daddr;
    dma_wdata = dwdata;
  endtask

  task automatic idle(input logic rst);
    drive(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic push_gnt(input logic stall, input logic we,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    gnt_q.push_back({16'(cyc), stall, we, ~we, addr, wdata});
  endtask

  task automatic push_rd(input logic [DATA_W-1:0] data);
    rd_q.push_back({16'(cyc + 1), data});
  endtask

  task automatic push_reg(input logic rv, input logic [DATA_W-1:0] rdata,
                          input logic [CNT_W-1:0] sc);
    reg_q.push_back({16'(cyc), rv, rdata, sc});
  endtask

  // CPU loads every cycle while DMA reads addr 5 continuously; with MAX_WAIT=4
  // every fifth contended cycle is a forced grant that stalls the CPU.
  task automatic contend(input int n, input logic [DATA_W-1:0] rexp);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0, 7'd10, 32'd0, 1'b1, 1'b0, 7'd5, 32'd0);
      if (i % 5 == 4) begin
        push_gnt(1'b1, 1'b0, 7'd5, 32'd0);
        push_rd(rexp);
      end
    end
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [57:0] eg;
    logic [47:0] er;
    logic [52:0] ereg;
    if (dma_gnt) begin
      if (gnt_q.size() == 0) begin
        cmp("unexpected_gnt", 64'({dm_addr, dm_wr}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        eg = gnt_q.pop_front();
        cmp("dma_gnt", 64'({16'(cyc), cpu_stall, dm_wr, dm_rd, dm_addr, dm_wdata}), 64'(eg));
      end
    end else if (cpu_rd || cpu_wr) begin
      cmp("cpu_pass", 64'({cpu_stall, dm_rd, dm_wr, dm_addr, dm_wdata}),
          64'({1'b0, cpu_rd, cpu_wr, cpu_addr, cpu_wdata}));
      if (cpu_rd) cmp("cpu_rdata", 64'(cpu_rdata), 64'(dm_rdata));
    end
    if (dma_rvalid) begin
      if (rd_q.size() == 0) begin
        cmp("unexpected_rvalid", 64'(dma_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        er = rd_q.pop_front();
        cmp("dma_rvalid", 64'({16'(cyc), dma_rdata}), 64'(er));
      end
    end
    if (reg_q.size() > 0 && reg_q[0][52:37] == 16'(cyc)) begin
      ereg = reg_q.pop_front();
      cmp("regs", 64'({16'(cyc), dma_rvalid, dma_rdata, stall_count}), 64'(ereg));
    end
    if (done && !leftovers_done) begin
      cmp("gnt_left", 64'(gnt_q.size()), 64'd0);
      cmp("rd_left", 64'(rd_q.size()), 64'd0);
      cmp("reg_left", 64'(reg_q.size()), 64'd0);
      leftovers_done <= 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    push_reg(1'b0, 32'd0, 4'd0);

    // DMA write into an idle port: granted at once, no stall
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF);
    push_gnt(1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
    idle(1'b0);

    // DMA read back: rvalid only in the cycle after the grant, data then holds
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd5, 32'd0);
    push_gnt(1'b0, 1'b0, 7'd5, 32'd0);
    push_rd(32'hDEADBEEF);
    idle(1'b0);
    idle(1'b0);
    push_reg(1'b0, 32'hDEADBEEF, 4'd0);

    // CPU store reaches memory, then DMA reads it
    drive(1'b0, 1'b0, 1'b1, 7'd20, 32'h12345678, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd20, 32'd0);
    push_gnt(1'b0, 1'b0, 7'd20, 32'd0);
    push_rd(32'h12345678);
    idle(1'b0);

    // DMA waits two busy cycles, then takes the first idle cycle without stalling
    drive(1'b0, 1'b1, 1'b0, 7'd10, 32'd0, 1'b1, 1'b0, 7'd5, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 7'd10, 32'd0, 1'b1, 1'b0, 7'd5, 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd5, 32'd0);
    push_gnt(1'b0, 1'b0, 7'd5, 32'd0);
    push_rd(32'hDEADBEEF);
    idle(1'b0);
    push_reg(1'b1, 32'hDEADBEEF, 4'd0);

    // 20 cycles of contention: forced grants 5 apart, four stalls
    contend(20, 32'hDEADBEEF);
    idle(1'b0);
    push_reg(1'b1, 32'hDEADBEEF, 4'd4);

    // reset in the cycle after a read grant clears the registered state
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd5, 32'd0);
    push_gnt(1'b0, 1'b0, 7'd5, 32'd0);
    push_rd(32'hDEADBEEF);
    idle(1'b1);
    idle(1'b0);
    push_reg(1'b0, 32'd0, 4'd0);

    // reset in the grant cycle itself: grant still shown, return cancelled
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'd20, 32'd0);
    push_gnt(1'b0, 1'b0, 7'd20, 32'd0);
    idle(1'b0);
    push_reg(1'b0, 32'd0, 4'd0);

    // drive the 4-bit stall counter to saturation and beyond
    contend(35, 32'hDEADBEEF);
    idle(1'b0);
    push_reg(1'b1, 32'hDEADBEEF, 4'd7);
    contend(40, 32'hDEADBEEF);
    idle(1'b0);
    push_reg(1'b1, 32'hDEADBEEF, 4'hF);
    contend(10, 32'hDEADBEEF);
    idle(1'b0);
    push_reg(1'b1, 32'hDEADBEEF, 4'hF);

    idle(1'b0);
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Shares the single-port data memory (dm) between the pipeline MEM stage and an external DMA/debug requester. The CPU normally owns the port. A waiting DMA request is served in idle MEM cycles, or by force after a bounded wait. A forced grant stalls the pipeline for one cycle. The block sits between stage 4 (MEM) and dm, and its stall output feeds the pipeline hold logic.

Parameters:
ADDR_W, 7, word-address width (dm index, alurslt_s4[8:2])
DATA_W, 32, data width
MAX_WAIT, 4, cycles a DMA request may wait behind CPU traffic before a forced grant; legal range 1..255
CNT_W, 16, width of the stall statistics counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
cpu_addr  in  ADDR_W  MEM-stage word address
cpu_rd  in  1  MEM-stage read (memread_s4)
cpu_wr  in  1  MEM-stage write (memwrite_s4)
cpu_wdata  in  DATA_W  MEM-stage store data
cpu_rdata  out  DATA_W  read data to MEM stage (combinational from dm)
cpu_stall  out  1  MEM access not performed this cycle; pipeline must hold stages 1-4
dma_req  in  1  DMA request; held with addr/we/wdata stable until dma_gnt
dma_we  in  1  1 = write, 0 = read
dma_addr  in  ADDR_W  DMA word address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  access performed this cycle (combinational, one-cycle pulse)
dma_rdata  out  DATA_W  registered read data
dma_rvalid  out  1  dma_rdata valid; one-cycle pulse, one cycle after a read grant
dm_addr  out  ADDR_W  to dm
dm_rd  out  1  to dm
dm_wr  out  1  to dm
dm_wdata  out  DATA_W  to dm
dm_rdata  in  DATA_W  from dm (combinational read)
stall_count  out  CNT_W  saturating count of cpu_stall cycles

Behaviour:
- Definitions: cpu_act = cpu_rd | cpu_wr. force = (wait_cnt == MAX_WAIT).
- Ownership (combinational, per cycle):
  - dma_own = dma_req & (~cpu_act | force).
  - Otherwise the CPU owns the port.
- When dma_own is true:
  - dm_addr = dma_addr, dm_wr = dma_we, dm_rd = ~dma_we, dm_wdata = dma_wdata.
  - dma_gnt = 1.
  - cpu_stall = cpu_act.
- When the CPU owns the port:
  - dm_* mirror the cpu_* inputs.
  - dma_gnt = 0, cpu_stall = 0.
- cpu_rdata = dm_rdata at all times. Its value is meaningful only when cpu_rd=1 and cpu_stall=0.
- wait_cnt (8-bit internal):
  - Reset and dma_gnt clear it to 0.
  - dma_req & ~dma_gnt increments it, saturating at MAX_WAIT.
  - ~dma_req clears it to 0.
- Fairness consequence: after a forced grant, wait_cnt=0. The CPU therefore wins at least the next MAX_WAIT contended cycles, so two forced grants are never back-to-back.
- DMA read return: on a read grant, dma_rdata <= dm_rdata and dma_rvalid <= 1 at the next edge. Otherwise dma_rvalid <= 0 and dma_rdata holds.
- A DMA write has no return phase; the transaction is complete at dma_gnt.
- stall_count increments on every cycle with cpu_stall=1 and saturates at all-ones.
- A stalled CPU access keeps its inputs stable (the pipeline holds). It is therefore performed on the next cycle, which the CPU always wins because wait_cnt was just cleared.
- Simultaneous cpu_rd & cpu_wr is illegal from the control decoder. If it occurs, both are passed through unchanged.
- Reset values: wait_cnt=0, dma_rvalid=0, dma_rdata=0, stall_count=0.
- During reset, combinational outputs still follow the rules above. An in-flight dma_rvalid pulse is cancelled by reset.
- Latency:
  - CPU access: 0 extra cycles uncontended, 1 cycle when forced-stalled.
  - DMA access: worst case MAX_WAIT+1 cycles from request to grant.

Decomposition:
- A shared package holds ADDR_W/DATA_W defaults, shared with dm and the CPU top.
- No typedefs are needed; ownership is a single-bit decision.
- One natural sub-module: dm_arb_wait (wait counter plus force flag).
- The stall_count saturating counter is inline.

Test Plan:
- Idle CPU (cpu_rd=cpu_wr=0), dma_req write addr 5 data 0xDEADBEEF -> dma_gnt same cycle, dm_wr=1 with dm_addr=5, cpu_stall=0, stall_count stays 0.
- DMA read addr 5 while CPU idle -> dma_gnt in cycle N, dma_rvalid=1 with dma_rdata=0xDEADBEEF in cycle N+1 only.
- CPU issues lw every cycle and DMA requests continuously (MAX_WAIT=4) -> gnt on 5th cycle of request, cpu_stall=1 that cycle, CPU access served next cycle, stall_count=1; pattern repeats every 5 cycles.
- Sustained contention for 20 cycles -> grants never on consecutive cycles, exactly 4 stall cycles, stall_count=4.
- Reset asserted the cycle after a read grant -> dma_rvalid=0 and dma_rdata=0 next cycle, wait_cnt=0, stall_count=0.
- Force stall_count to near saturation (CNT_W=4, 16 forced stalls) -> holds at 0xF.
